// File: rtl/pipe_reg_skid_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_reg_skid_if                                                         |
// | EX->MEM bundle handshake bus for the skid-buffered pipeline register.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface pipe_reg_skid_if #(
  parameter int WB_W   = 2,
  parameter int M_W    = 3,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [WB_W-1:0]   in_wb;
  logic [M_W-1:0]    in_m;
  logic [DATA_W-1:0] in_addr;
  logic              in_zero;
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_rdata2;
  logic [REG_W-1:0]  in_dst;

  logic              out_valid;
  logic              out_ready;
  logic [WB_W-1:0]   out_wb;
  logic [M_W-1:0]    out_m;
  logic [DATA_W-1:0] out_addr;
  logic              out_zero;
  logic [DATA_W-1:0] out_alu;
  logic [DATA_W-1:0] out_rdata2;
  logic [REG_W-1:0]  out_dst;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output in_valid, flush, in_wb, in_m, in_addr, in_zero, in_alu, in_rdata2, in_dst,
    output out_ready,
    input  in_ready, out_valid, out_wb, out_m, out_addr, out_zero, out_alu,
    input  out_rdata2, out_dst, stall_cnt
  );

  modport slave (
    input  in_valid, flush, in_wb, in_m, in_addr, in_zero, in_alu, in_rdata2, in_dst,
    input  out_ready,
    output in_ready, out_valid, out_wb, out_m, out_addr, out_zero, out_alu,
    output out_rdata2, out_dst, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_reg_skid.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_reg_skid                                                            |
// | Two-entry (main + skid) EX/MEM pipeline register with registered ready, |
// | flush, control zeroing on bubbles and a saturating stall counter.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pipe_reg_skid #(
  parameter int WB_W   = 2,
  parameter int M_W    = 3,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic           clk,
  input  logic           rst,
  pipe_reg_skid_if.slave bus
);

  localparam int CTL_W = WB_W + M_W;
  localparam int BW    = CTL_W + 3*DATA_W + 1 + REG_W;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]       r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [BW-1:0]    r_main;
  logic [BW-1:0]    r_skid;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [1:0]       w_state_nxt;
  logic             w_accept;
  logic             w_take;
  logic             w_ld_main_in;
  logic             w_ld_main_skid;
  logic             w_ld_skid;
  logic             w_clr_ctl;
  logic [BW-1:0]    w_in_bundle;

  assign w_in_bundle = {bus.in_wb, bus.in_m, bus.in_addr, bus.in_zero,
                        bus.in_alu, bus.in_rdata2, bus.in_dst};

  assign w_accept = bus.in_valid & r_in_ready & ~bus.flush;
  assign w_take   = r_out_valid & bus.out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    w_clr_ctl      = 1'b0;
    if (bus.flush) begin
      w_state_nxt = S_EMPTY;
      w_clr_ctl   = 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_ld_main_in = 1'b1;
            w_state_nxt  = S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && w_take) begin
            w_ld_main_in = 1'b1;
          end else if (w_accept) begin
            w_ld_skid   = 1'b1;
            w_state_nxt = S_TWO;
          end else if (w_take) begin
            w_clr_ctl   = 1'b1;
            w_state_nxt = S_EMPTY;
          end
        end
        S_TWO: begin
          // in_ready is low here, so only a take can move the state
          if (w_take) begin
            w_ld_main_skid = 1'b1;
            w_state_nxt    = S_ONE;
          end
        end
        default: begin
          w_clr_ctl   = 1'b1;
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main      <= '0;
      r_skid      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != S_TWO);
      r_out_valid <= (w_state_nxt != S_EMPTY);
      if (w_ld_main_in) begin
        r_main <= w_in_bundle;
      end else if (w_ld_main_skid) begin
        r_main <= r_skid;
      end else if (w_clr_ctl) begin
        // Bubbles carry no control; data fields keep their last value
        r_main <= {{CTL_W{1'b0}}, r_main[BW-CTL_W-1:0]};
      end
      if (w_ld_skid) begin
        r_skid <= w_in_bundle;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !bus.out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.stall_cnt = r_stall_cnt;
  assign {bus.out_wb, bus.out_m, bus.out_addr, bus.out_zero,
          bus.out_alu, bus.out_rdata2, bus.out_dst} = r_main;

endmodule
`default_nettype wire
